clock_display_mux: RTL and testbench
====================================

CLOCK_DISPLAY_MUX -- requirements
Module: clock_display_mux

Interface
REQ-001 Parameter SCAN_DIV, default 4, clock cycles each digit stays enabled (legal values 2..255).
REQ-002 Parameter BLINK_DIV, default 32, clock cycles per blink half-period (legal values 2..65535).
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset; synchronous and active-high.
REQ-005 hour1  input  2  hours tens digit, BCD.
REQ-006 hour2  input  4  hours units digit, BCD.
REQ-007 min1  input  3  minutes tens digit, BCD.
REQ-008 min2  input  4  minutes units digit, BCD.
REQ-009 sec1  input  3  seconds tens digit, BCD.
REQ-010 sec2  input  4  seconds units digit, BCD.
REQ-011 set_field  input  2  field being edited: 0 = none, 1 = hours, 2 = minutes, 3 = seconds.
REQ-012 an  output  6  digit enables, active-low, one-hot-low; an[0] = hour1 (leftmost) through an[5] = sec2.
REQ-013 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-014 dp  output  1  decimal point used as the colon, active-low.

Function
REQ-015 The prescaler SHALL count 0..SCAN_DIV-1 every cycle and wrap to 0; the wrap cycle is the scan tick.
REQ-016 The digit index SHALL advance 0,1,2,3,4,5,0 on each scan tick, so a full frame is 6*SCAN_DIV cycles.
REQ-017 an, seg and dp SHALL be registered from the current index and the current digit inputs, with 1-cycle latency.
REQ-018 an SHALL be low only at bit [index]; no cycle outside reset SHALL have zero or two bits low.
REQ-019 seg SHALL use this decode (hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
REQ-020 hour2, min2 or sec2 values 10..15 SHALL display a dash (seg=3F).
REQ-021 Tens inputs SHALL be zero-extended to 4 bits before decode.
REQ-022 dp SHALL be 0 while index is 1 or 3 (colon after hours and after minutes), and 1 otherwise.
REQ-023 A digit input that changes mid-slot SHALL appear on seg on the next cycle; the scan timing SHALL NOT restart.
REQ-024 The blink counter SHALL count 0..BLINK_DIV-1 and toggle blink_phase on wrap; it runs independently of the scan.
REQ-025 When blink_phase=1 and the current index belongs to the field selected by set_field, seg SHALL be 7F (blank) while an stays active.
REQ-026 A change of set_field SHALL take effect on the next registered output; the blink counter SHALL NOT reset.

Reset
REQ-027 While reset=1 at a clock edge, all of the following SHALL hold on the following cycle:
- prescaler = 0, index = 0, blink counter = 0, blink_phase = 0
- an = 3F, seg = 7F, dp = 1
REQ-028 On the first edge with reset=0, outputs SHALL show index 0 (an=3E).
REQ-029 Reset asserted mid-frame SHALL abort the scan immediately; there SHALL be no partial-slot carry-over.

Configuration
REQ-030 With macro CLOCK_DISPLAY_BLINK_EN defined, the blink counter and REQ-024..026 blanking SHALL be present.
REQ-031 Without it, the following SHALL hold:
- no blink logic is synthesised
- set_field is ignored
- all digits always display per REQ-019..020

Verification
REQ-032 Apply reset 10 cycles, release, digits 1,1,3,0,5,5, set_field=0 -> an sequence 3E,3D,3B,37,2F,1F, each held 4 cycles, repeating every 24 cycles.
REQ-033 Same digits -> seg per slot 79,79,30,40,12,12; dp=0 only in slots 1 and 3.
REQ-034 hour2=12, min2=15 -> seg=3F in slots 1 and 3; all other slots decode normally.
REQ-035 With CLOCK_DISPLAY_BLINK_EN, set_field=2 -> slots 2,3 show seg=7F for 32 cycles, then digits for 32 cycles, alternating; slots 0,1,4,5 are never blanked. Without the macro, no blanking occurs.
REQ-036 Assert reset for 1 cycle mid-slot 4 -> next cycle an=3F, seg=7F, dp=1; first cycle after release an=3E.
REQ-037 Change sec2 from 5 to 9 during slot 5 -> seg goes 12 to 10 on the next cycle; an timing unchanged.

Source files
------------

// File: rtl/clock_display_mux.sv
// clock_display_mux: six-digit multiplexed 7-segment clock display; blinking of the edited field is built only with CLOCK_DISPLAY_BLINK_EN
module clock_display_mux #(
  parameter int SCAN_DIV = 4,
  parameter int BLINK_DIV = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] hour1,
  input  logic [3:0] hour2,
  input  logic [2:0] min1,
  input  logic [3:0] min2,
  input  logic [2:0] sec1,
  input  logic [3:0] sec2,
  input  logic [1:0] set_field,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  logic [7:0] presc;
  logic [2:0] idx;
  logic [3:0] digit;
  logic [6:0] seg_d;
  logic       tick;
  logic       blank;
  assign tick = presc == 8'(SCAN_DIV - 1);
  // scan prescaler and digit index
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      idx <= '0;
    end else begin
      presc <= tick ? 8'd0 : presc + 8'd1;
      if (tick) idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end
  end
  // select the digit for the current slot, tens digits zero-extended
  always_comb begin
    digit = idx == 3'd0 ? {2'b0, hour1} :
            idx == 3'd1 ? hour2 :
            idx == 3'd2 ? {1'b0, min1} :
            idx == 3'd3 ? min2 :
            idx == 3'd4 ? {1'b0, sec1} : sec2;
  end
  // BCD to active-low segments; 10..15 show a dash
  always_comb begin
    case (digit)
      4'd0: seg_d = 7'h40;
      4'd1: seg_d = 7'h79;
      4'd2: seg_d = 7'h24;
      4'd3: seg_d = 7'h30;
      4'd4: seg_d = 7'h19;
      4'd5: seg_d = 7'h12;
      4'd6: seg_d = 7'h02;
      4'd7: seg_d = 7'h78;
      4'd8: seg_d = 7'h00;
      4'd9: seg_d = 7'h10;
      default: seg_d = 7'h3F;
    endcase
  end
`ifdef CLOCK_DISPLAY_BLINK_EN
  logic [15:0] bcnt;
  logic        bphase;
  // free-running blink timer, independent of the scan and of set_field
  always_ff @(posedge clk) begin
    if (reset) begin
      bcnt <= '0;
      bphase <= 1'b0;
    end else begin
      bcnt <= (bcnt == 16'(BLINK_DIV - 1)) ? 16'd0 : bcnt + 16'd1;
      if (bcnt == 16'(BLINK_DIV - 1)) bphase <= ~bphase;
    end
  end
  assign blank = bphase && (set_field == 2'(idx[2:1] + 3'd1));
`else
  logic unused_set_field;
  assign unused_set_field = ^set_field;
  assign blank = 1'b0;
`endif
  // registered display outputs, colon after hours and minutes
  always_ff @(posedge clk) begin
    if (reset) begin
      an <= 6'h3F;
      seg <= 7'h7F;
      dp <= 1'b1;
    end else begin
      an <= ~(6'd1 << idx);
      seg <= blank ? 7'h7F : seg_d;
      dp <= !(idx == 3'd1 || idx == 3'd3);
    end
  end
endmodule

// File: tb/tb_clock_display_mux.sv
// tb_clock_display_mux: model-based and directed checks of clock_display_mux
module tb_clock_display_mux;
  localparam int SD = 4;
  localparam int BD = 32;
`ifdef CLOCK_DISPLAY_BLINK_EN
  localparam bit BL = 1'b1;
`else
  localparam bit BL = 1'b0;
`endif
  logic clk = 0, reset = 1;
  logic [1:0] hour1 = 1, set_field = 0;
  logic [3:0] hour2 = 1, min2 = 0, sec2 = 5;
  logic [2:0] min1 = 3, sec1 = 5;
  logic [5:0] an;
  logic [6:0] seg;
  logic dp;
  int errors = 0, checks = 0, k = 0;
  bit armed = 0;
  logic [6:0] lut [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [5:0] an_t [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
  logic [6:0] seg_t [6] = '{7'h79, 7'h79, 7'h30, 7'h40, 7'h12, 7'h12};
  clock_display_mux #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk(clk), .reset(reset), .hour1(hour1), .hour2(hour2), .min1(min1), .min2(min2),
    .sec1(sec1), .sec2(sec2), .set_field(set_field), .an(an), .seg(seg), .dp(dp)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (k=%0d)", name, act, exp, k);
    end
  endtask
  // reference model: output after the k-th edge since reset shows slot ((k-1)/SD)%6
  always @(posedge clk) begin
    logic [5:0] ea;
    logic [6:0] es;
    logic ed;
    int s, d;
    if (reset) begin
      k = 0;
      armed = 1;
      ea = 6'h3F; es = 7'h7F; ed = 1;
    end else begin
      k++;
      s = ((k - 1) / SD) % 6;
      case (s)
        0: d = hour1;
        1: d = hour2;
        2: d = min1;
        3: d = min2;
        4: d = sec1;
        default: d = sec2;
      endcase
      es = d > 9 ? 7'h3F : lut[d];
      if (BL && ((k - 1) / BD) % 2 == 1 && set_field != 0 && s / 2 == set_field - 1) es = 7'h7F;
      ea = 6'h3F & ~(6'd1 << s);
      ed = (s == 1 || s == 3) ? 1'b0 : 1'b1;
    end
    #1;
    if (armed) begin
      chk("model_an", an, ea);
      chk("model_seg", seg, es);
      chk("model_dp", dp, ed);
    end
  end
  // at a negedge, wait until the coming edge shows slot s at position off (ph<0: any blink phase)
  task automatic wait_for(input int s, input int off, input int ph);
    bit ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = ((k / SD) % 6 == s) && (k % SD == off) && (ph < 0 || (k / BD) % 2 == ph);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_slot%0d: not reached, expected within 400 cycles", s);
    end
  endtask
  task automatic after_edge;
    @(posedge clk);
    #2;
  endtask
  initial begin
    repeat (10) @(negedge clk);
    chk("reset_an", an, 6'h3F);
    chk("reset_seg", seg, 7'h7F);
    chk("reset_dp", dp, 1);
    reset = 0;
    for (int e = 1; e <= 25; e++) begin
      after_edge();
      if (e % SD == 1) begin
        chk("seq_an", an, an_t[((e - 1) / SD) % 6]);
        chk("seq_seg", seg, seg_t[((e - 1) / SD) % 6]);
        chk("seq_dp", dp, (((e - 1) / SD) % 6 == 1 || ((e - 1) / SD) % 6 == 3) ? 0 : 1);
      end
    end
    repeat (40) @(negedge clk);
    hour2 = 12; min2 = 15;
    wait_for(1, 0, -1); after_edge(); chk("dash_h2", seg, 7'h3F);
    wait_for(2, 0, -1); after_edge(); chk("m1_normal", seg, 7'h30);
    wait_for(3, 0, -1); after_edge(); chk("dash_m2", seg, 7'h3F);
    wait_for(4, 0, -1); after_edge(); chk("s1_normal", seg, 7'h12);
    @(negedge clk);
    hour2 = 1; min2 = 0; set_field = 2;
    wait_for(2, 0, 1); after_edge(); chk("blink_m1", seg, BL ? 7'h7F : 7'h30);
    chk("blink_an", an, 6'h3B);
    wait_for(0, 0, 1); after_edge(); chk("noblink_h1", seg, 7'h79);
    wait_for(3, 0, 0); after_edge(); chk("phase0_m2", seg, 7'h40);
    wait_for(3, 1, 1); after_edge(); chk("blink_m2", seg, BL ? 7'h7F : 7'h40);
    wait_for(5, 0, 1); after_edge(); chk("noblink_s2", seg, 7'h12);
    repeat (70) @(negedge clk);
    set_field = 0;
    wait_for(5, 1, -1); after_edge(); chk("s2_before", seg, 7'h12);
    @(negedge clk);
    sec2 = 9;
    after_edge(); chk("s2_after", seg, 7'h10);
    chk("s2_an", an, 6'h1F);
    wait_for(4, 2, -1);
    reset = 1;
    after_edge();
    chk("midrst_an", an, 6'h3F);
    chk("midrst_seg", seg, 7'h7F);
    chk("midrst_dp", dp, 1);
    @(negedge clk);
    reset = 0;
    after_edge();
    chk("rel_an", an, 6'h3E);
    chk("rel_seg", seg, 7'h79);
    repeat (60) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
